// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RISC15 pipeline stage controller.
// Holds the controller state encoding and the NOP instruction word.
package pipe_ctrl_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_MULTI = 1'b1
   } state_t;

   // Word loaded into IF/ID or ID/EX when a stage is flushed.
   localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit priority encoder with one-hot clear mask.
// Ports: vec (N) in; idx (W) lowest set index; onehot (N) that bit; any = |vec.
module prio_enc_lsb #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot,
   output logic         any
);

   assign any = |vec;

   // Two's-complement trick isolates the lowest set bit.
   assign onehot = vec & (~vec + N'(1));

   // Scan downward so the lowest set bit is the last writer.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Write/flush sequencer for the five RISC15 pipeline registers, with LM/SM expansion.
// Ports: clk, reset (sync, low); hazard/branch/mem/lmsm inputs; *_wr_n, *_flush, lmsm_*, stall_cnt.
module pipe_stage_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NREG = 8,
   parameter int IDXW = 3,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ld_use_hazard,
   input  logic            br_taken_ex,
   input  logic            mem_busy,
   input  logic            lmsm_start,
   input  logic [NREG-1:0] lmsm_mask,
   output logic            pc_wr_n,
   output logic            ifid_wr_n,
   output logic            idex_wr_n,
   output logic            exmem_wr_n,
   output logic            memwb_wr_n,
   output logic            ifid_flush,
   output logic            idex_flush,
   output logic            lmsm_active,
   output logic [IDXW-1:0] lmsm_idx,
   output logic            lmsm_last,
   output logic [CNTW-1:0] stall_cnt
);

   state_t          state;
   logic [NREG-1:0] rem_mask;

   logic [NREG-1:0] src;
   logic [NREG-1:0] onehot;
   logic [NREG-1:0] rest;
   logic [IDXW-1:0] enc_idx;
   logic            src_any;
   logic            more;
   logic            multi;
   logic            start_ok;
   logic            base_act;

   // wr_n bit order: pc, ifid, idex, exmem, memwb
   logic [4:0]      wr_n;
   logic            fl_ifid;
   logic            fl_idex;
   logic            act;

   assign multi = (state == ST_MULTI);

   // In RUN the micro-op comes from the new instruction's mask;
   // in MULTI from what is left of the expansion.
   assign src = multi ? rem_mask : lmsm_mask;

   prio_enc_lsb #(
      .N (NREG),
      .W (IDXW)
   ) u_enc (
      .vec    (src),
      .idx    (enc_idx),
      .onehot (onehot),
      .any    (src_any)
   );

   assign rest = src & ~onehot;
   assign more = |rest;

   // A load-use stall outranks a new LM/SM, so it gates the start.
   assign start_ok = lmsm_start && !ld_use_hazard && src_any;
   assign base_act = multi ? src_any : start_ok;

   always_comb begin
      wr_n    = '0;
      fl_ifid = 1'b0;
      fl_idex = 1'b0;
      act     = 1'b0;
      if (reset) begin
         act = base_act;
         if (mem_busy) begin
            wr_n = '1;
         end else if (br_taken_ex) begin
            fl_ifid = 1'b1;
            fl_idex = 1'b1;
            act     = 1'b0;
         end else if (multi) begin
            wr_n[4:3] = {2{more}};
         end else if (ld_use_hazard) begin
            wr_n[4:3] = 2'b11;
            fl_idex   = 1'b1;
         end else if (start_ok && more) begin
            wr_n[4:3] = 2'b11;
         end
      end
   end

   assign pc_wr_n     = wr_n[4];
   assign ifid_wr_n   = wr_n[3];
   assign idex_wr_n   = wr_n[2];
   assign exmem_wr_n  = wr_n[1];
   assign memwb_wr_n  = wr_n[0];
   assign ifid_flush  = fl_ifid;
   assign idex_flush  = fl_idex;
   assign lmsm_active = act;
   assign lmsm_idx    = act ? enc_idx : '0;
   assign lmsm_last   = act & ~more;

   // mem_busy freezes the expansion; a concurrent branch is
   // seen again once memory is ready.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_RUN;
         rem_mask  <= '0;
         stall_cnt <= '0;
      end else begin
         if (wr_n[4] && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
         end
         if (!mem_busy) begin
            if (br_taken_ex) begin
               state    <= ST_RUN;
               rem_mask <= '0;
            end else if (multi) begin
               rem_mask <= rest;
               if (!more) begin
                  state <= ST_RUN;
               end
            end else if (start_ok && more) begin
               rem_mask <= rest;
               state    <= ST_MULTI;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl against a queue-based model.
// Second instance uses CNTW=4 to reach stall counter saturation.
module tb_pipe_stage_ctrl;

   localparam int NREG = 8;
   localparam int IDXW = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ld = 1'b0;
   logic       br = 1'b0;
   logic       mem = 1'b0;
   logic       st = 1'b0;
   logic [7:0] mask = '0;

   logic pc_wr_n, ifid_wr_n, idex_wr_n, exmem_wr_n, memwb_wr_n;
   logic ifid_flush, idex_flush, lmsm_active, lmsm_last;
   logic [IDXW-1:0] lmsm_idx;
   logic [15:0] stall_cnt;

   logic b_pc, b_ifid, b_idex, b_exmem, b_memwb;
   logic b_iff, b_idf, b_act, b_last;
   logic [IDXW-1:0] b_idx;
   logic [3:0] b_cnt;

   logic [11:0] got;
   logic [11:0] got_b;

   int errs = 0;
   int checks = 0;

   int q[$];
   int nq[$];
   int cnt = 0;
   int ncnt = 0;
   logic [11:0] exp_v;
   logic [15:0] exp_c16;
   logic [3:0]  exp_c4;

   always #5 clk = ~clk;

   pipe_stage_ctrl #(
      .NREG (NREG),
      .IDXW (IDXW),
      .CNTW (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .ld_use_hazard (ld),
      .br_taken_ex   (br),
      .mem_busy      (mem),
      .lmsm_start    (st),
      .lmsm_mask     (mask),
      .pc_wr_n       (pc_wr_n),
      .ifid_wr_n     (ifid_wr_n),
      .idex_wr_n     (idex_wr_n),
      .exmem_wr_n    (exmem_wr_n),
      .memwb_wr_n    (memwb_wr_n),
      .ifid_flush    (ifid_flush),
      .idex_flush    (idex_flush),
      .lmsm_active   (lmsm_active),
      .lmsm_idx      (lmsm_idx),
      .lmsm_last     (lmsm_last),
      .stall_cnt     (stall_cnt)
   );

   pipe_stage_ctrl #(
      .NREG (NREG),
      .IDXW (IDXW),
      .CNTW (4)
   ) dut4 (
      .clk           (clk),
      .reset         (reset),
      .ld_use_hazard (ld),
      .br_taken_ex   (br),
      .mem_busy      (mem),
      .lmsm_start    (st),
      .lmsm_mask     (mask),
      .pc_wr_n       (b_pc),
      .ifid_wr_n     (b_ifid),
      .idex_wr_n     (b_idex),
      .exmem_wr_n    (b_exmem),
      .memwb_wr_n    (b_memwb),
      .ifid_flush    (b_iff),
      .idex_flush    (b_idf),
      .lmsm_active   (b_act),
      .lmsm_idx      (b_idx),
      .lmsm_last     (b_last),
      .stall_cnt     (b_cnt)
   );

   assign got = {pc_wr_n, ifid_wr_n, idex_wr_n, exmem_wr_n,
                 memwb_wr_n, ifid_flush, idex_flush,
                 lmsm_active, lmsm_idx, lmsm_last};
   assign got_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb,
                   b_iff, b_idf, b_act, b_idx, b_last};

   // q holds register indices still to be issued by an
   // expansion in progress; empty means normal flow.
   function automatic void model_eval();
      int bits[$];
      int cur;
      bit act;
      bit lst;
      bit [4:0] wr;
      bit [1:0] fl;
      bits = {};
      for (int i = 0; i < NREG; i++) begin
         if (mask[i]) bits.push_back(i);
      end
      nq = q;
      ncnt = cnt;
      act = 0;
      cur = 0;
      lst = 0;
      wr = '0;
      fl = '0;
      if (!reset) begin
         nq = {};
         ncnt = 0;
      end else begin
         if (q.size() > 0) begin
            act = 1;
            cur = q[0];
            lst = (q.size() == 1);
         end else if (st && !ld && bits.size() > 0) begin
            act = 1;
            cur = bits[0];
            lst = (bits.size() == 1);
         end
         if (mem) begin
            wr = 5'b11111;
         end else if (br) begin
            fl = 2'b11;
            act = 0;
            cur = 0;
            lst = 0;
            nq = {};
         end else if (q.size() > 0) begin
            if (q.size() > 1) wr = 5'b11000;
            void'(nq.pop_front());
         end else if (ld) begin
            wr = 5'b11000;
            fl = 2'b01;
         end else if (act && !lst) begin
            wr = 5'b11000;
            nq = bits;
            void'(nq.pop_front());
         end
         if (wr[4]) ncnt = cnt + 1;
      end
      exp_v = {wr, fl, act, 3'(cur), lst};
      exp_c16 = (cnt > 65535) ? 16'hffff : 16'(cnt);
      exp_c4 = (cnt > 15) ? 4'hf : 4'(cnt);
   endfunction

   task automatic drive(input logic r, input logic l,
                        input logic b, input logic m,
                        input logic s, input logic [7:0] mk);
      reset = r;
      ld = l;
      br = b;
      mem = m;
      st = s;
      mask = mk;
   endtask

   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic tick();
      @(posedge clk);
      q = nq;
      cnt = ncnt;
      #1;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 3; c++) begin
         drive(c == 2, 0, 0, 0, 0, 8'h00);
         settle();
         if (got !== exp_v) begin
            errs++;
            $display("FAIL reset out c=%0d got=%h exp=%h", c, got, exp_v);
         end
         if (stall_cnt !== exp_c16) begin
            errs++;
            $display("FAIL reset cnt got=%0d exp=%0d", stall_cnt, exp_c16);
         end
         checks += 2;
         if (c == 2) begin
            if ({pc_wr_n, lmsm_active, stall_cnt} !== 18'd0) begin
               errs++;
               $display("FAIL reset idle pc=%b act=%b cnt=%0d exp=0",
                        pc_wr_n, lmsm_active, stall_cnt);
            end
            checks++;
         end
         tick();
      end
   endtask

   task automatic test_ld_use();
      for (int c = 0; c < 2; c++) begin
         drive(1, c == 0, 0, 0, 0, 8'h00);
         settle();
         if (got !== exp_v) begin
            errs++;
            $display("FAIL ld_use out c=%0d got=%h exp=%h", c, got, exp_v);
         end
         checks++;
         if (c == 0 && {pc_wr_n, ifid_wr_n, idex_flush} !== 3'b111) begin
            errs++;
            $display("FAIL ld_use stall got=%b exp=111",
                     {pc_wr_n, ifid_wr_n, idex_flush});
         end
         if (c == 1 && stall_cnt !== 16'd1) begin
            errs++;
            $display("FAIL ld_use cnt got=%0d exp=1", stall_cnt);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_lmsm();
      int idx_e[3] = '{2, 5, 7};
      bit last_e[3] = '{0, 0, 1};
      bit pc_e[3] = '{1, 1, 0};
      for (int c = 0; c < 4; c++) begin
         drive(1, 0, 0, 0, c == 0, 8'ha4);
         settle();
         if (got !== exp_v) begin
            errs++;
            $display("FAIL lmsm out c=%0d got=%h exp=%h", c, got, exp_v);
         end
         checks++;
         if (c < 3) begin
            if (lmsm_idx !== 3'(idx_e[c]) || lmsm_last !== last_e[c] ||
                pc_wr_n !== pc_e[c] || lmsm_active !== 1'b1) begin
               errs++;
               $display("FAIL lmsm seq c=%0d idx=%0d last=%b pc=%b exp %0d %b %b",
                        c, lmsm_idx, lmsm_last, pc_wr_n,
                        idx_e[c], last_e[c], pc_e[c]);
            end
            checks++;
         end else begin
            if (stall_cnt !== 16'd3) begin
               errs++;
               $display("FAIL lmsm cnt got=%0d exp=3", stall_cnt);
            end
            checks++;
         end
         tick();
      end
   endtask

   task automatic test_branch_abort();
      for (int c = 0; c < 5; c++) begin
         drive(1, 0, c == 1, 0, c == 0 || c == 3,
               (c == 3) ? 8'h00 : 8'ha4);
         settle();
         if (got !== exp_v) begin
            errs++;
            $display("FAIL br_abort out c=%0d got=%h exp=%h", c, got, exp_v);
         end
         checks++;
         if (c == 1 && {ifid_flush, idex_flush, lmsm_active} !== 3'b110) begin
            errs++;
            $display("FAIL br_abort flush got=%b exp=110",
                     {ifid_flush, idex_flush, lmsm_active});
         end
         if (c >= 2 && {pc_wr_n, lmsm_active} !== 2'b00) begin
            errs++;
            $display("FAIL br_abort after c=%0d got=%b exp=00",
                     c, {pc_wr_n, lmsm_active});
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_mem_busy();
      for (int c = 0; c < 6; c++) begin
         drive(1, 0, c >= 1 && c <= 4, c >= 1 && c <= 3, c == 0, 8'ha4);
         settle();
         if (got !== exp_v) begin
            errs++;
            $display("FAIL mem_busy out c=%0d got=%h exp=%h", c, got, exp_v);
         end
         checks++;
         if (c >= 1 && c <= 3) begin
            if (got[11:7] !== 5'h1f || lmsm_idx !== 3'd5 ||
                got[6:5] !== 2'b00) begin
               errs++;
               $display("FAIL mem_busy hold c=%0d got=%h exp wr=1f idx=5",
                        c, got);
            end
            checks++;
         end
         if (c == 4) begin
            if ({ifid_flush, idex_flush} !== 2'b11) begin
               errs++;
               $display("FAIL mem_busy flush got=%b exp=11",
                        {ifid_flush, idex_flush});
            end
            checks++;
         end
         if (c == 5) begin
            if (lmsm_active !== 1'b0) begin
               errs++;
               $display("FAIL mem_busy after act=%b exp=0", lmsm_active);
            end
            checks++;
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++) begin
         drive(c != 1, 0, 0, 0, c == 0, 8'ha4);
         settle();
         if (got !== exp_v || stall_cnt !== exp_c16) begin
            errs++;
            $display("FAIL rst_mid c=%0d got=%h cnt=%0d exp=%h cnt=%0d",
                     c, got, stall_cnt, exp_v, exp_c16);
         end
         checks++;
         if (c == 2 && {lmsm_active, stall_cnt} !== 17'd0) begin
            errs++;
            $display("FAIL rst_mid idle act=%b cnt=%0d exp 0 0",
                     lmsm_active, stall_cnt);
         end
         checks++;
         tick();
      end
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 21; c++) begin
         drive(1, c < 20, 0, 0, 0, 8'h00);
         settle();
         if (got_b !== exp_v || b_cnt !== exp_c4) begin
            errs++;
            $display("FAIL sat c=%0d got=%h cnt=%0d exp=%h cnt=%0d",
                     c, got_b, b_cnt, exp_v, exp_c4);
         end
         checks++;
         if (c == 20) begin
            if (b_cnt !== 4'd15 || stall_cnt !== 16'd20) begin
               errs++;
               $display("FAIL sat end cnt4=%0d cnt16=%0d exp 15 20",
                        b_cnt, stall_cnt);
            end
            checks++;
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive($urandom_range(49) != 0,
               $urandom_range(4) == 0,
               $urandom_range(7) == 0,
               $urandom_range(5) == 0,
               $urandom_range(2) == 0,
               8'($urandom));
         settle();
         if (got !== exp_v || stall_cnt !== exp_c16) begin
            errs++;
            $display("FAIL rand c=%0d got=%h cnt=%0d exp=%h cnt=%0d",
                     c, got, stall_cnt, exp_v, exp_c16);
         end
         if (got_b !== exp_v || b_cnt !== exp_c4) begin
            errs++;
            $display("FAIL rand4 c=%0d got=%h cnt=%0d exp=%h cnt=%0d",
                     c, got_b, b_cnt, exp_v, exp_c4);
         end
         checks += 2;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_ld_use();
      test_lmsm();
      test_branch_abort();
      test_mem_busy();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
